// File: rtl/fpadd_pkg.sv
// fpadd_pkg: shared constants and FSM encoding for the FP16 accumulate
// sequencer.
//   FP16_ZERO / FP16_ONE : FP16 bit patterns for 0.0 and 1.0
//   state_t              : 2-bit sequencer state encoding
package fpadd_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fpadd_in_fifo.sv
// fpadd_in_fifo: DEPTH x W synchronous first-word-fall-through FIFO.
// Ports:
//   CLK, RST      clock, asynchronous active-low reset
//   i_push/i_data write request and word (ignored while full)
//   i_pop         read request (ignored while empty)
//   o_data        word at the head, valid while !o_empty
//   o_full        DEPTH words stored
//   o_empty       no words stored
module fpadd_in_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fpadd_acc_seq.sv
// fpadd_acc_seq: sequences packets of FP16 elements through an external
// pipelined adder and presents one sum per packet.
// Ports:
//   CLK, RST                    clock, asynchronous active-low reset
//   in_valid/in_ready           element stream handshake
//   in_data/in_last             FP16 element, last-of-packet marker
//   add_a/add_b                 registered adder operands (sum, element)
//   add_out/add_ovf/add_sub     adder result and flags, LAT edges later
//   res_valid/res_ready         packet result handshake
//   res_data/res_ovf/res_sub    packet sum and sticky adder flags
//   res_count                   elements in packet, saturating
//   busy                        sequencer not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first element of a packet
// ACC     | waiting for the next element to issue to the adder
// WAIT    | adder in flight, LAT+1 cycles, operands held
// DONE    | result presented until accepted
module fpadd_acc_seq
    import fpadd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    parameter int CNTW  = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_data,
    input  logic            in_last,
    output logic [15:0]     add_a,
    output logic [15:0]     add_b,
    input  logic [15:0]     add_out,
    input  logic            add_ovf,
    input  logic            add_sub,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [15:0]     res_data,
    output logic            res_ovf,
    output logic            res_sub,
    output logic [CNTW-1:0] res_count,
    output logic            busy
);

    localparam int WW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    state_t          r_state;
    logic [15:0]     r_add_a;
    logic [15:0]     r_add_b;
    logic [15:0]     r_acc;
    logic            r_ovf;
    logic            r_sub;
    logic [CNTW-1:0] r_count;
    logic            r_res_valid;
    logic            r_busy;
    logic            r_last;
    logic [WW-1:0]   r_wait;

    logic [16:0]     w_fifo_data;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [15:0]     w_elem;
    logic            w_elem_last;

    assign in_ready    = !w_full;
    assign w_elem      = w_fifo_data[15:0];
    assign w_elem_last = w_fifo_data[16];
    // Only IDLE and ACC consume elements; DONE leaves the FIFO filling.
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_ACC));

    fpadd_in_fifo #(
        .DEPTH (DEPTH),
        .W     (17)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (in_valid),
        .i_data  ({in_last, in_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_add_a     <= FP16_ZERO;
            r_add_b     <= FP16_ZERO;
            r_acc       <= FP16_ZERO;
            r_ovf       <= 1'b0;
            r_sub       <= 1'b0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_last      <= 1'b0;
            r_wait      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        // First element seeds the sum directly, no adder pass.
                        r_acc   <= w_elem;
                        r_count <= CNTW'(1);
                        r_ovf   <= 1'b0;
                        r_sub   <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_elem_last) begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (!w_empty) begin
                        r_add_a <= r_acc;
                        r_add_b <= w_elem;
                        r_last  <= w_elem_last;
                        if (r_count != {CNTW{1'b1}}) begin
                            r_count <= r_count + CNTW'(1);
                        end
                        r_wait  <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Final cycle: the adder result for the held operands is
                    // present on add_out.
                    if (r_wait == WW'(LAT)) begin
                        r_acc <= add_out;
                        r_ovf <= r_ovf | add_ovf;
                        r_sub <= r_sub | add_sub;
                        if (r_last) begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_acc;
    assign res_ovf   = r_ovf;
    assign res_sub   = r_sub;
    assign res_count = r_count;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fpadd_acc_seq.sv
// tb_fpadd_acc_seq: directed bench for fpadd_acc_seq with a behavioural
// two-stage FP16 adder (positive operands, truncating) attached.
module tb_fpadd_acc_seq;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int CNTW  = 8;

    logic            CLK;
    logic            RST;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_data;
    logic            in_last;
    logic [15:0]     add_a;
    logic [15:0]     add_b;
    logic [15:0]     add_out;
    logic            add_ovf;
    logic            add_sub;
    logic            res_valid;
    logic            res_ready;
    logic [15:0]     res_data;
    logic            res_ovf;
    logic            res_sub;
    logic [CNTW-1:0] res_count;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_issue = 0;
    int issue_cyc = 0;
    int first_issue_cyc = 0;
    int t_valid = 0;
    logic [31:0] prev_ops = '0;

    fpadd_acc_seq #(.DEPTH(DEPTH), .LAT(LAT), .CNTW(CNTW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .add_ovf   (add_ovf),
        .add_sub   (add_sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .res_sub   (res_sub),
        .res_count (res_count),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {ovf, sub, result}
    function automatic logic [17:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a, b;
        logic [5:0]  ea, eb, e;
        logic [11:0] ma, mb, s;
        int d;
        if (x[14:0] >= y[14:0]) begin a = x; b = y; end
        else begin a = y; b = x; end
        ea = (a[14:10] == 5'd0) ? 6'd1 : {1'b0, a[14:10]};
        eb = (b[14:10] == 5'd0) ? 6'd1 : {1'b0, b[14:10]};
        ma = {1'b0, (a[14:10] != 5'd0), a[9:0]};
        mb = {1'b0, (b[14:10] != 5'd0), b[9:0]};
        d  = int'(ea - eb);
        mb = (d > 11) ? 12'd0 : (mb >> d);
        s  = ma + mb;
        e  = ea;
        if (s[11]) begin
            s = s >> 1;
            e = e + 6'd1;
        end else if (!s[10]) begin
            e = 6'd0;
        end
        if (e >= 6'd31) return {1'b1, 1'b0, 16'h7C00};
        return {1'b0, (e == 6'd0), 1'b0, e[4:0], s[9:0]};
    endfunction

    logic [15:0] p_sum;
    logic        p_ovf, p_sub;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_sum <= '0; p_ovf <= 1'b0; p_sub <= 1'b0;
            add_out <= '0; add_ovf <= 1'b0; add_sub <= 1'b0;
        end else begin
            {p_ovf, p_sub, p_sum} <= fp16_add(add_a, add_b);
            add_out <= p_sum;
            add_ovf <= p_ovf;
            add_sub <= p_sub;
        end
    end

    // Adder issue monitor: any change of the operand pair is one issue.
    always @(posedge CLK) begin
        cyc++;
        #1;
        if ({add_a, add_b} !== prev_ops) begin
            n_issue++;
            issue_cyc = cyc;
            if (n_issue == 1) first_issue_cyc = cyc;
            prev_ops = {add_a, add_b};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [15:0] d, input logic l);
        int k;
        k = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && k < 200) begin
            @(posedge CLK); #2; k++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(posedge CLK); #2;
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(input logic [15:0] ed, input logic [15:0] mask,
                              input logic [CNTW-1:0] ec, input logic eo,
                              input logic es, input string nm);
        int k;
        k = 0;
        while (!res_valid && k < 2000) begin
            @(posedge CLK); #2; k++;
        end
        t_valid = cyc;
        n_cmp++;
        if (res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_valid_timeout: res_valid=%b required 1", nm, res_valid);
        end else begin
            n_cmp++;
            if ((res_data & mask) !== (ed & mask)) begin
                n_err++;
                $display("FAIL %s_data: got %h required %h (mask %h)", nm, res_data, ed, mask);
            end
            n_cmp++;
            if (res_count !== ec) begin
                n_err++;
                $display("FAIL %s_count: got %0d required %0d", nm, res_count, ec);
            end
            n_cmp++;
            if (res_ovf !== eo) begin
                n_err++;
                $display("FAIL %s_ovf: got %b required %b", nm, res_ovf, eo);
            end
            n_cmp++;
            if (res_sub !== es) begin
                n_err++;
                $display("FAIL %s_sub: got %b required %b", nm, res_sub, es);
            end
        end
        res_ready = 1'b1;
        @(posedge CLK); #2;
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_release: res_valid=%b required 0", nm, res_valid);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        n_cmp++;
        if ({add_a, add_b, res_data} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data: add_a=%h add_b=%h res_data=%h required 0", add_a, add_b, res_data);
        end
        n_cmp++;
        if ({res_valid, res_ovf, res_sub, busy} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: valid/ovf/sub/busy=%b required 0000", {res_valid, res_ovf, res_sub, busy});
        end
        n_cmp++;
        if (res_count !== '0) begin
            n_err++;
            $display("FAIL reset_count: got %0d required 0", res_count);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        RST = 1'b1;
        @(posedge CLK); #2;
    endtask

    task automatic test_single();
        n_issue = 0;
        push(16'h3C00, 1'b1);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early_valid: got %b required 0", res_valid);
        end
        @(posedge CLK); #2;
        n_cmp++;
        if (res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_valid_latency: got %b required 1", res_valid);
        end
        get_result(16'h3C00, 16'hFFFF, 8'd1, 1'b0, 1'b0, "single");
        n_cmp++;
        if (n_issue !== 0 || add_a !== 16'h0 || add_b !== 16'h0) begin
            n_err++;
            $display("FAIL single_no_issue: issues=%0d add_a=%h add_b=%h required 0/0000/0000", n_issue, add_a, add_b);
        end
    endtask

    task automatic test_two();
        n_issue = 0;
        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b1);
        get_result(16'h4200, 16'hFFFF, 8'd2, 1'b0, 1'b0, "two");
        n_cmp++;
        if (n_issue !== 1) begin
            n_err++;
            $display("FAIL two_issues: got %0d required 1", n_issue);
        end
        n_cmp++;
        if (t_valid - issue_cyc !== LAT + 1) begin
            n_err++;
            $display("FAIL two_wait_len: got %0d required %0d", t_valid - issue_cyc, LAT + 1);
        end
        n_cmp++;
        if (add_a !== 16'h3C00 || add_b !== 16'h4000) begin
            n_err++;
            $display("FAIL two_operands: add_a=%h add_b=%h required 3c00/4000", add_a, add_b);
        end
    endtask

    task automatic test_three();
        n_issue = 0;
        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b1);
        get_result(16'h4400, 16'hFFFF, 8'd3, 1'b0, 1'b0, "three");
        n_cmp++;
        if (n_issue !== 2) begin
            n_err++;
            $display("FAIL three_issues: got %0d required 2", n_issue);
        end
        n_cmp++;
        if (issue_cyc - first_issue_cyc !== LAT + 2) begin
            n_err++;
            $display("FAIL three_spacing: got %0d required %0d", issue_cyc - first_issue_cyc, LAT + 2);
        end
    endtask

    task automatic test_ovf();
        push(16'h7BFF, 1'b0);
        push(16'h7BFF, 1'b1);
        get_result(16'h7C00, 16'h7C00, 8'd2, 1'b1, 1'b0, "ovf");
        push(16'h3800, 1'b1);
        get_result(16'h3800, 16'hFFFF, 8'd1, 1'b0, 1'b0, "ovf_next");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            push(16'h0000, (i == 299));
        end
        get_result(16'h0000, 16'hFFFF, 8'hFF, 1'b0, 1'b1, "saturate");
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v [6];
        logic [15:0] got [8];
        int n_acc, n_got, k;
        logic acc_now;
        exp_v[0] = 16'h3800; exp_v[1] = 16'h3C00; exp_v[2] = 16'h4000;
        exp_v[3] = 16'h4200; exp_v[4] = 16'h4400; exp_v[5] = 16'h4500;
        res_ready = 1'b0;
        push(exp_v[0], 1'b1);
        k = 0;
        while (!res_valid && k < 50) begin
            @(posedge CLK); #2; k++;
        end
        n_acc = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (n_acc < 5);
            in_data  = exp_v[(n_acc < 5) ? n_acc + 1 : 5];
            in_last  = 1'b1;
            acc_now  = in_valid && in_ready;
            @(posedge CLK); #2;
            if (acc_now) n_acc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n_acc !== DEPTH) begin
            n_err++;
            $display("FAIL bp_accepted: got %0d required %0d", n_acc, DEPTH);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_in_ready: got %b required 0", in_ready);
        end
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== exp_v[0]) begin
            n_err++;
            $display("FAIL bp_held: valid=%b data=%h required 1/%h", res_valid, res_data, exp_v[0]);
        end
        res_ready = 1'b1;
        n_got = 0;
        for (int c = 0; c < 40; c++) begin
            if (res_valid) begin
                if (n_got < 8) got[n_got] = res_data;
                n_got++;
            end
            @(posedge CLK); #2;
        end
        res_ready = 1'b0;
        n_cmp++;
        if (n_got !== DEPTH + 1) begin
            n_err++;
            $display("FAIL bp_drain_count: got %0d required %0d", n_got, DEPTH + 1);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < n_got) begin
                n_cmp++;
                if (got[i] !== exp_v[i]) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: got %h required %h", i, got[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midwait();
        int k;
        n_issue = 0;
        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b0);
        push(16'h4000, 1'b1);
        k = 0;
        while (n_issue == 0 && k < 20) begin
            @(posedge CLK); #2; k++;
        end
        n_cmp++;
        if (busy !== 1'b1 || n_issue == 0) begin
            n_err++;
            $display("FAIL rst_pre_busy: busy=%b issues=%0d required 1/>0", busy, n_issue);
        end
        #2;
        RST = 1'b0;
        #1;
        n_cmp++;
        if ({add_a, add_b, res_data} !== 48'h0 || res_count !== '0) begin
            n_err++;
            $display("FAIL rst_async_data: add_a=%h add_b=%h res_data=%h count=%0d required 0",
                     add_a, add_b, res_data, res_count);
        end
        n_cmp++;
        if ({res_valid, res_ovf, res_sub, busy, in_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL rst_async_flags: valid/ovf/sub/busy/in_ready=%b required 00001",
                     {res_valid, res_ovf, res_sub, busy, in_ready});
        end
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b1;
        @(posedge CLK); #2;
        push(16'h4000, 1'b1);
        get_result(16'h4000, 16'hFFFF, 8'd1, 1'b0, 1'b0, "after_rst");
        repeat (10) @(posedge CLK);
        #2;
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_leftover: valid=%b busy=%b required 0/0", res_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_three();
        test_ovf();
        test_saturate();
        test_back_to_back();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpadd_acc_seq.md
Name: fpadd_acc_seq

Overview:
- Upstream sequencer for the pipelined FP16 adder `fpadd`.
- Accepts a valid/ready stream of FP16 values grouped into packets (the `in_last` flag marks the final element).
- Drives the adder's `a`/`b` operands, waits out the adder latency, and feeds the result back as the running sum.
- Presents one FP16 sum per packet, plus sticky overflow/subnormal flags and an element count.

Parameters:
- DEPTH, 4, input FIFO entries (power of 2, ≥2).
- LAT, 2, fpadd latency in clock edges, from operands captured to `out` updated.
- CNTW, 8, width of the element counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input element valid.
- in_ready  out  1  high while the FIFO is not full.
- in_data  in  16  FP16 element.
- in_last  in  1  element is the last of its packet.
- add_a  out  16  adder operand A (registered), set to the running sum.
- add_b  out  16  adder operand B (registered), set to the new element.
- add_out  in  16  adder result.
- add_ovf  in  1  adder overflow flag.
- add_sub  in  1  adder subnormal/zero flag.
- res_valid  out  1  packet result valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  16  FP16 packet sum.
- res_ovf  out  1  sticky OR of `add_ovf` over the packet.
- res_sub  out  1  sticky OR of `add_sub` over the packet.
- res_count  out  CNTW  elements in the packet, saturating at all-ones.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (RST low, async):
  - FIFO emptied; FSM to IDLE.
  - `add_a`, `add_b`, `res_data`, `res_count` cleared to 0.
  - `res_valid`, `res_ovf`, `res_sub`, `busy` cleared to 0.
  - A reset mid-packet discards the packet and any FIFO contents; no partial result is emitted.
- Input FIFO:
  - Push when `in_valid && in_ready`; stores {in_last, in_data}.
  - `in_ready = !full`, combinational from the registered count.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Pop only when the FSM consumes an element; never pop when empty.
- FSM states: IDLE, ACC, WAIT, DONE.
  - IDLE, FIFO non-empty:
    - Pop; acc <= element (no adder operation for the first element); count <= 1; flags cleared.
    - If `last`, go to DONE, else ACC.
  - ACC, FIFO non-empty:
    - Pop; `add_a` <= acc, `add_b` <= element; latch `last`; count += 1 (saturating).
    - Wait counter <= 0; go to WAIT.
  - ACC, FIFO empty: stay in ACC.
  - WAIT:
    - Lasts exactly LAT+1 cycles; `add_a`/`add_b` are held stable throughout.
    - On the edge ending the final WAIT cycle: acc <= `add_out`; `res_ovf |= add_ovf`; `res_sub |= add_sub`.
    - Then go to DONE if the latched `last` is set, else ACC.
  - DONE:
    - `res_valid`=1; `res_data`=acc, with its flags and count.
    - Outputs are held stable until `res_ready`.
    - On `res_valid && res_ready`, go to IDLE.
    - No FIFO pops occur in DONE; the FIFO keeps accepting until full.
- Cost per added element: LAT+2 cycles (4 at the default).
- Single-element packet: handshake accepted at edge e0, popped at e1, `res_valid` high from e1.
- `res_count` saturates; the arithmetic is unaffected by saturation.
- The `in_last` flag on an element that arrives while the FSM is in DONE belongs to the next packet.

Decomposition:
- Package `fpadd_pkg` holds:
  - FP16 constants: FP16_ZERO=16'h0000, FP16_ONE=16'h3C00.
  - The FSM state encoding (2-bit).
- One sub-module: `fpadd_in_fifo`, a parameterised DEPTH×17 synchronous FIFO with full/empty flags and the same async active-low reset.

Test Plan:
- Single packet {3C00(last)}:
  - `res_valid` rises one cycle after the pop.
  - res_data=3C00, res_count=1, ovf=0, sub=0; `add_a`/`add_b` never change.
- Packet {3C00, 4000(last)} with `fpadd` attached:
  - res_data=4200 (3.0), res_count=2, flags 0.
  - `add_a`=3C00 and `add_b`=4000 held for LAT+1 cycles.
- Packet {3C00, 3C00, 4000(last)}:
  - res_data=4400 (4.0), res_count=3.
  - Exactly 2 adder issues spaced 4 cycles apart.
- Packet {7BFF, 7BFF(last)}:
  - res_ovf=1; res_data exponent field=5'b11111.
  - Next packet {3800(last)} gives res_data=3800 with ovf=0 (flags cleared between packets).
- Backpressure: hold res_ready=0 and present 1-element packets continuously.
  - After the first result, exactly DEPTH further pushes are accepted; then `in_ready`=0.
  - Raising res_ready drains all results in order, with no loss or duplication.
- Reset mid-WAIT of a 3-element packet:
  - All outputs are 0 immediately (async).
  - A new packet {4000(last)} afterwards yields res_data=4000, res_count=1.
